// File: rtl/core_pkg.sv
// Shared definitions for the five-stage core: load funct3 encodings, the
// default NOP word and the MEM/WB register update actions.
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Named with a suffix so a module parameter called NOP_INSN can default to it
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'd0,
    UPD_HOLD    = 2'd1,
    UPD_KILL    = 2'd2,
    UPD_BUBBLE  = 2'd3
  } upd_e;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    ext8 = {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    ext16 = {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/half from the raw memory word,
// extends it per load type and flags accesses that are not naturally aligned.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] datai,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and half-word lane selection from the offset
  always_comb begin
    byte_s = datai[7:0];
    case (off)
      2'd0:    byte_s = datai[7:0];
      2'd1:    byte_s = datai[15:8];
      2'd2:    byte_s = datai[23:16];
      2'd3:    byte_s = datai[31:24];
      default: byte_s = datai[7:0];
    endcase
    if (off[1]) begin
      half_s = datai[31:16];
    end else begin
      half_s = datai[15:0];
    end
  end

  // Extension and misalignment per load type; unknown types pass the word through
  always_comb begin
    data     = datai;
    misalign = 1'b0;
    case (funct3)
      F3_LB:   data = ext8(byte_s, 1'b1);
      F3_LBU:  data = ext8(byte_s, 1'b0);
      F3_LH: begin
        data     = ext16(half_s, 1'b1);
        misalign = off[0];
      end
      F3_LHU: begin
        data     = ext16(half_s, 1'b0);
        misalign = off[0];
      end
      F3_LW: begin
        data     = datai;
        misalign = (off != 2'd0);
      end
      default: begin
        data     = datai;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: validity tracking, flush/hold/bubble handling,
// aligned load data, qualified register-write strobe and a bubble counter.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int          RADDR_W    = 5,
  parameter logic [31:0] NOP_INSN   = NOP_INSN_DEFAULT,
  parameter int          LOAD_ALIGN = 1,
  parameter int          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               valid_mem,
  input  logic [31:0]        ir_mem,
  input  logic [31:0]        pc_mem,
  input  logic [31:0]        aluo_mem,
  input  logic [31:0]        datai,
  input  logic               mem_ready,
  input  logic [RADDR_W-1:0] rd_mem,
  input  logic               memread_mem,
  input  logic [2:0]         ld_funct3_mem,
  input  logic               datatoreg_mem,
  input  logic               regwrite_mem,
  output logic               mem_stall,
  output logic               valid_wb,
  output logic [31:0]        pc_wb,
  output logic [31:0]        ir_wb,
  output logic [31:0]        aluo_wb,
  output logic [31:0]        mdr_wb,
  output logic [RADDR_W-1:0] rd_wb,
  output logic               datatoreg_wb,
  output logic               regwrite_wb,
  output logic               misalign_wb,
  output logic [31:0]        wb_data,
  output logic [CNT_W-1:0]   bubble_cnt
);

  upd_e        upd_s;
  logic [31:0] align_data_s;
  logic        align_mis_s;
  logic        misalign_s;
  logic        regwrite_s;

  generate
    if (LOAD_ALIGN != 0) begin : g_align
      load_align u_align (
        .datai    (datai),
        .off      (aluo_mem[1:0]),
        .funct3   (ld_funct3_mem),
        .data     (align_data_s),
        .misalign (align_mis_s)
      );
    end else begin : g_raw
      assign align_data_s = datai;
      assign align_mis_s  = 1'b0;
    end
  endgenerate

  assign mem_stall  = valid_mem & memread_mem & ~mem_ready;
  assign misalign_s = memread_mem & align_mis_s;
  assign regwrite_s = regwrite_mem & valid_mem & (rd_mem != {RADDR_W{1'b0}}) & ~misalign_s;
  assign wb_data    = datatoreg_wb ? mdr_wb : aluo_wb;

  // Update action: flush beats hold, hold beats a memory-wait bubble
  always_comb begin
    upd_s = UPD_CAPTURE;
    if (flush) begin
      upd_s = UPD_KILL;
    end else if (!en) begin
      upd_s = UPD_HOLD;
    end else if (mem_stall) begin
      upd_s = UPD_BUBBLE;
    end else begin
      upd_s = UPD_CAPTURE;
    end
  end

  // WB field registers; kill and bubble clear validity but keep the data fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_wb     <= 1'b0;
      pc_wb        <= 32'h0000_0000;
      ir_wb        <= 32'h0000_0000;
      aluo_wb      <= 32'h0000_0000;
      mdr_wb       <= 32'h0000_0000;
      rd_wb        <= {RADDR_W{1'b0}};
      datatoreg_wb <= 1'b0;
      regwrite_wb  <= 1'b0;
      misalign_wb  <= 1'b0;
    end else begin
      case (upd_s)
        UPD_KILL, UPD_BUBBLE: begin
          valid_wb    <= 1'b0;
          regwrite_wb <= 1'b0;
          misalign_wb <= 1'b0;
          ir_wb       <= NOP_INSN;
        end
        UPD_CAPTURE: begin
          valid_wb     <= valid_mem;
          pc_wb        <= pc_mem;
          ir_wb        <= ir_mem;
          aluo_wb      <= aluo_mem;
          mdr_wb       <= align_data_s;
          rd_wb        <= rd_mem;
          datatoreg_wb <= datatoreg_mem;
          regwrite_wb  <= regwrite_s;
          misalign_wb  <= misalign_s;
        end
        default: begin
          valid_wb <= valid_wb;
        end
      endcase
    end
  end

  // Saturating count of memory-wait bubbles (a flush in the same cycle does not count)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (upd_s == UPD_BUBBLE && bubble_cnt != {CNT_W{1'b1}}) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic
// against a behavioural model of the WB register state.
module tb_mem_wb_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, flush = 1'b0, valid_mem = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir_mem = 32'h0, pc_mem = 32'h0, aluo_mem = 32'h0, datai = 32'h0;
  logic [4:0]  rd_mem = 5'd0;
  logic        memread_mem = 1'b0, datatoreg_mem = 1'b0, regwrite_mem = 1'b0;
  logic [2:0]  ld_funct3_mem = 3'd0;

  logic        mem_stall, valid_wb, datatoreg_wb, regwrite_wb, misalign_wb;
  logic [31:0] pc_wb, ir_wb, aluo_wb, mdr_wb, wb_data;
  logic [4:0]  rd_wb;
  logic [15:0] bubble_cnt;

  logic        s_mem_stall, s_valid_wb, s_datatoreg_wb, s_regwrite_wb, s_misalign_wb;
  logic [31:0] s_pc_wb, s_ir_wb, s_aluo_wb, s_mdr_wb, s_wb_data;
  logic [4:0]  s_rd_wb;
  logic [1:0]  s_bubble_cnt;

  int nvec = 0;
  int nerr = 0;

  // Model of the WB state
  logic        m_valid, m_dtr, m_rw, m_mis;
  logic [31:0] m_pc, m_ir, m_aluo, m_mdr;
  logic [4:0]  m_rd;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_mem(valid_mem),
    .ir_mem(ir_mem), .pc_mem(pc_mem), .aluo_mem(aluo_mem), .datai(datai),
    .mem_ready(mem_ready), .rd_mem(rd_mem), .memread_mem(memread_mem),
    .ld_funct3_mem(ld_funct3_mem), .datatoreg_mem(datatoreg_mem),
    .regwrite_mem(regwrite_mem), .mem_stall(mem_stall), .valid_wb(valid_wb),
    .pc_wb(pc_wb), .ir_wb(ir_wb), .aluo_wb(aluo_wb), .mdr_wb(mdr_wb),
    .rd_wb(rd_wb), .datatoreg_wb(datatoreg_wb), .regwrite_wb(regwrite_wb),
    .misalign_wb(misalign_wb), .wb_data(wb_data), .bubble_cnt(bubble_cnt)
  );

  mem_wb_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_mem(valid_mem),
    .ir_mem(ir_mem), .pc_mem(pc_mem), .aluo_mem(aluo_mem), .datai(datai),
    .mem_ready(mem_ready), .rd_mem(rd_mem), .memread_mem(memread_mem),
    .ld_funct3_mem(ld_funct3_mem), .datatoreg_mem(datatoreg_mem),
    .regwrite_mem(regwrite_mem), .mem_stall(s_mem_stall), .valid_wb(s_valid_wb),
    .pc_wb(s_pc_wb), .ir_wb(s_ir_wb), .aluo_wb(s_aluo_wb), .mdr_wb(s_mdr_wb),
    .rd_wb(s_rd_wb), .datatoreg_wb(s_datatoreg_wb), .regwrite_wb(s_regwrite_wb),
    .misalign_wb(s_misalign_wb), .wb_data(s_wb_data), .bubble_cnt(s_bubble_cnt)
  );

  // Loaded value from plain shifts and two's-complement arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    int b, h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(input int off, input logic [2:0] f3);
    return ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 == 1)) || (f3 == 3'b010 && off != 0);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_dtr = 1'b0; m_rw = 1'b0; m_mis = 1'b0;
    m_pc = 32'h0; m_ir = 32'h0; m_aluo = 32'h0; m_mdr = 32'h0; m_rd = 5'd0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  // Advance the model by one edge using current inputs, then clock the DUT
  task automatic tick();
    int off;
    off = int'(aluo_mem[1:0]);
    if (flush || (en && valid_mem && memread_mem && !mem_ready)) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mis = 1'b0; m_ir = NOP;
      if (!flush) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
    end else if (en) begin
      m_valid = valid_mem; m_pc = pc_mem; m_ir = ir_mem; m_aluo = aluo_mem;
      m_mdr = ref_load(datai, off, ld_funct3_mem);
      m_rd = rd_mem; m_dtr = datatoreg_mem;
      m_mis = memread_mem && ref_mis(off, ld_funct3_mem);
      m_rw = regwrite_mem && valid_mem && (rd_mem != 5'd0) && !m_mis;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] aluo,
                       input logic [4:0] rd, input logic mr, input logic [2:0] f3,
                       input logic dtr, input logic rw);
    valid_mem = v; ir_mem = ir; pc_mem = pc_mem + 32'd4; aluo_mem = aluo; rd_mem = rd;
    memread_mem = mr; ld_funct3_mem = f3; datatoreg_mem = dtr; regwrite_mem = rw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if ({valid_wb, regwrite_wb, misalign_wb, datatoreg_wb} !== 4'b0) begin nerr++; $display("FAIL reset_flags got %b exp 0000", {valid_wb, regwrite_wb, misalign_wb, datatoreg_wb}); end
    nvec++; if (ir_wb !== 32'h0) begin nerr++; $display("FAIL reset_ir got %h exp 00000000", ir_wb); end
    nvec++; if ({pc_wb, aluo_wb, mdr_wb} !== 96'h0 || rd_wb !== 5'd0) begin nerr++; $display("FAIL reset_data got pc %h aluo %h mdr %h rd %0d exp 0", pc_wb, aluo_wb, mdr_wb, rd_wb); end
    nvec++; if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 2'd0) begin nerr++; $display("FAIL reset_cnt got %0d/%0d exp 0", bubble_cnt, s_bubble_cnt); end
    #3 rst = 1'b0;
    en = 1'b1; mem_ready = 1'b1;
  endtask

  task automatic test_capture();
    drive(1'b1, 32'h0020_82b3, 32'h0000_1234, 5'd5, 1'b0, 3'b010, 1'b0, 1'b1);
    tick();
    nvec++; if (regwrite_wb !== 1'b1) begin nerr++; $display("FAIL cap_regwrite got %b exp 1", regwrite_wb); end
    nvec++; if (wb_data !== 32'h0000_1234) begin nerr++; $display("FAIL cap_wb_data got %h exp 00001234", wb_data); end
    nvec++; if (valid_wb !== 1'b1 || rd_wb !== 5'd5 || ir_wb !== 32'h0020_82b3) begin nerr++; $display("FAIL cap_fields got v %b rd %0d ir %h exp 1 5 002082b3", valid_wb, rd_wb, ir_wb); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b000, 3'b101};
    logic [31:0] adrs [3] = '{32'h0000_0101, 32'h0000_0203, 32'h0000_0302};
    logic [31:0] exps [3] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF};
    datai = 32'h80FF_7F01; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0283, adrs[i], 5'd6, 1'b1, f3s[i], 1'b1, 1'b1);
      tick();
      nvec++; if (mdr_wb !== exps[i]) begin nerr++; $display("FAIL load_%0d mdr_wb got %h exp %h", i, mdr_wb, exps[i]); end
      nvec++; if (wb_data !== exps[i] || regwrite_wb !== 1'b1) begin nerr++; $display("FAIL load_%0d wb got %h rw %b exp %h 1", i, wb_data, regwrite_wb, exps[i]); end
    end
  endtask

  task automatic test_misaligned_lw();
    drive(1'b1, 32'h0000_2283, 32'h0000_0402, 5'd3, 1'b1, 3'b010, 1'b1, 1'b1);
    tick();
    nvec++; if (misalign_wb !== 1'b1 || regwrite_wb !== 1'b0) begin nerr++; $display("FAIL mis_lw got mis %b rw %b exp 1 0", misalign_wb, regwrite_wb); end
    nvec++; if (mdr_wb !== 32'h80FF_7F01) begin nerr++; $display("FAIL mis_lw_mdr got %h exp 80ff7f01", mdr_wb); end
  endtask

  task automatic test_mem_wait();
    datai = $urandom;
    drive(1'b1, 32'h0000_2383, 32'h0000_0100, 5'd7, 1'b1, 3'b010, 1'b1, 1'b1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (mem_stall !== 1'b1) begin nerr++; $display("FAIL wait_stall_%0d got %b exp 1", i, mem_stall); end
      tick();
      nvec++; if (valid_wb !== 1'b0 || ir_wb !== NOP) begin nerr++; $display("FAIL wait_bubble_%0d got v %b ir %h exp 0 %h", i, valid_wb, ir_wb, NOP); end
    end
    nvec++; if (bubble_cnt !== 16'd3 || s_bubble_cnt !== 2'd3) begin nerr++; $display("FAIL wait_cnt got %0d/%0d exp 3", bubble_cnt, s_bubble_cnt); end
    mem_ready = 1'b1;
    #1;
    nvec++; if (mem_stall !== 1'b0) begin nerr++; $display("FAIL wait_ready_stall got %b exp 0", mem_stall); end
    tick();
    nvec++; if (valid_wb !== 1'b1 || mdr_wb !== datai || regwrite_wb !== 1'b1 || rd_wb !== 5'd7) begin nerr++; $display("FAIL wait_load got v %b mdr %h rw %b rd %0d exp 1 %h 1 7", valid_wb, mdr_wb, regwrite_wb, rd_wb, datai); end
    nvec++; if (bubble_cnt !== 16'd3) begin nerr++; $display("FAIL wait_cnt_after got %0d exp 3", bubble_cnt); end
  endtask

  task automatic test_flush_stall_hold();
    drive(1'b1, 32'h1111_1111, 32'hAAAA_0000, 5'd9, 1'b0, 3'b000, 1'b0, 1'b1);
    flush = 1'b1; en = 1'b0;
    tick();
    nvec++; if (valid_wb !== 1'b0 || ir_wb !== NOP || regwrite_wb !== 1'b0) begin nerr++; $display("FAIL flush_en0 got v %b ir %h rw %b exp 0 %h 0", valid_wb, ir_wb, regwrite_wb, NOP); end
    nvec++; if (aluo_wb !== m_aluo || rd_wb !== m_rd || mdr_wb !== m_mdr) begin nerr++; $display("FAIL flush_hold_data got aluo %h rd %0d mdr %h exp %h %0d %h", aluo_wb, rd_wb, mdr_wb, m_aluo, m_rd, m_mdr); end
    en = 1'b1; memread_mem = 1'b1; mem_ready = 1'b0;
    tick();
    nvec++; if (bubble_cnt !== 16'(m_cnt) || m_cnt != 3) begin nerr++; $display("FAIL flush_stall_cnt got %0d exp 3", bubble_cnt); end
    flush = 1'b0; mem_ready = 1'b1;
    drive(1'b1, $urandom, $urandom, 5'd12, 1'b0, 3'b010, 1'b1, 1'b1);
    tick();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, 5'(i + 20), 1'b1, 3'b000, 1'b0, 1'b1);
      mem_ready = 1'(i);
      tick();
      nvec++; if ({valid_wb, pc_wb, ir_wb, aluo_wb, mdr_wb, rd_wb, datatoreg_wb, regwrite_wb, misalign_wb, bubble_cnt}
                  !== {m_valid, m_pc, m_ir, m_aluo, m_mdr, m_rd, m_dtr, m_rw, m_mis, 16'(m_cnt)}) begin
        nerr++; $display("FAIL hold_%0d got v %b ir %h aluo %h rd %0d cnt %0d exp %b %h %h %0d %0d", i, valid_wb, ir_wb, aluo_wb, rd_wb, bubble_cnt, m_valid, m_ir, m_aluo, m_rd, m_cnt);
      end
    end
    en = 1'b1; mem_ready = 1'b1;
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 32'h0000_0013, 32'h0000_5555, 5'd0, 1'b0, 3'b000, 1'b0, 1'b1);
    tick();
    nvec++; if (regwrite_wb !== 1'b0 || valid_wb !== 1'b1) begin nerr++; $display("FAIL rd_zero got rw %b v %b exp 0 1", regwrite_wb, valid_wb); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h0000_2283, 32'h0000_0200, 5'd4, 1'b1, 3'b010, 1'b1, 1'b1);
    mem_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    nvec++; if (valid_wb !== 1'b0 || ir_wb !== 32'h0 || aluo_wb !== 32'h0 || bubble_cnt !== 16'd0 || s_bubble_cnt !== 2'd0) begin
      nerr++; $display("FAIL async_rst got v %b ir %h aluo %h cnt %0d exp 0", valid_wb, ir_wb, aluo_wb, bubble_cnt);
    end
    #2 rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    nvec++; if (valid_wb !== 1'b1 || aluo_wb !== 32'h0000_0200 || bubble_cnt !== 16'd0) begin nerr++; $display("FAIL async_rst_after got v %b aluo %h cnt %0d exp 1 00000200 0", valid_wb, aluo_wb, bubble_cnt); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h0000_2283, 32'h0000_0300, 5'd8, 1'b1, 3'b010, 1'b1, 1'b1);
    mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++; if (s_bubble_cnt !== 2'((i < 3) ? i : 3) || bubble_cnt !== 16'(i)) begin
        nerr++; $display("FAIL sat_%0d got %0d/%0d exp %0d/%0d", i, s_bubble_cnt, bubble_cnt, (i < 3) ? i : 3, i);
      end
    end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      datai = $urandom;
      drive(($urandom_range(0, 4) != 0), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom));
      #1;
      nvec++; if (mem_stall !== (valid_mem & memread_mem & ~mem_ready)) begin nerr++; $display("FAIL rnd_%0d mem_stall got %b", n, mem_stall); end
      tick();
      nvec++; if ({valid_wb, regwrite_wb, misalign_wb, datatoreg_wb} !== {m_valid, m_rw, m_mis, m_dtr}) begin
        nerr++; $display("FAIL rnd_%0d flags got v/rw/mis/dtr %b exp %b", n, {valid_wb, regwrite_wb, misalign_wb, datatoreg_wb}, {m_valid, m_rw, m_mis, m_dtr});
      end
      nvec++; if ({pc_wb, ir_wb, aluo_wb, rd_wb} !== {m_pc, m_ir, m_aluo, m_rd}) begin
        nerr++; $display("FAIL rnd_%0d fields got pc %h ir %h aluo %h rd %0d exp %h %h %h %0d", n, pc_wb, ir_wb, aluo_wb, rd_wb, m_pc, m_ir, m_aluo, m_rd);
      end
      nvec++; if (mdr_wb !== m_mdr || wb_data !== (m_dtr ? m_mdr : m_aluo)) begin
        nerr++; $display("FAIL rnd_%0d data got mdr %h wb %h exp %h %h", n, mdr_wb, wb_data, m_mdr, m_dtr ? m_mdr : m_aluo);
      end
      nvec++; if (bubble_cnt !== 16'(m_cnt) || s_bubble_cnt !== 2'(m_cnt2)) begin
        nerr++; $display("FAIL rnd_%0d cnt got %0d/%0d exp %0d/%0d", n, bubble_cnt, s_bubble_cnt, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_extract();
    test_misaligned_lw();
    test_mem_wait();
    test_flush_stall_hold();
    test_rd_zero();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
